// File: rtl/lsu_ctrl.sv
// RV32I load/store initiator for a word-organised synchronous ram.
// Sub-word stores are read-modify-write; busy stalls the CPU until done.

module lsu_lane (
  input  logic       sel,
  input  logic [7:0] rbyte,
  input  logic [7:0] wbyte,
  output logic [7:0] mbyte
);
  assign mbyte = sel ? wbyte : rbyte;
endmodule

module lsu_ctrl #(
  parameter int n  = 32,
  parameter int AW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req,
  input  logic          memWrite,
  input  logic [2:0]    funct3,
  input  logic [AW-1:0] addr,
  input  logic [n-1:0]  wdata,
  output logic [n-1:0]  rdata,
  output logic          done,
  output logic          err,
  output logic          busy,
  output logic          ramR,
  output logic          ramW,
  output logic [AW-1:0] ramAddr,
  output logic [n-1:0]  ramDataW,
  input  logic [n-1:0]  ramDataR
);
  localparam int NUM_LANES = n / 8;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] CAP  = 3'd2;
  localparam logic [2:0] MRG  = 3'd3;
  localparam logic [2:0] WR   = 3'd4;

  // Only the byte offset and low store half are needed after acceptance;
  // the word address lives in ramAddr.
  typedef struct packed {
    logic        wr;
    logic [2:0]  f3;
    logic [1:0]  boff;
    logic [15:0] wlo;
  } req_t;

  logic [2:0] state;
  req_t       cur;
  logic       bad;

  assign busy = (state != IDLE);

  always_comb begin
    bad = 1'b0;
    case (funct3)
      3'b000:         bad = 1'b0;
      3'b001, 3'b101: bad = addr[0] | (memWrite & funct3[2]);
      3'b010:         bad = (addr[1:0] != 2'b00);
      3'b100:         bad = memWrite;
      default:        bad = 1'b1;
    endcase
  end

  logic [NUM_LANES-1:0][7:0] rlane, wlane, mlane;
  logic [NUM_LANES-1:0]      lmask;
  logic                      is_byte;

  assign rlane   = ramDataR;
  assign is_byte = (cur.f3[1:0] == 2'b00);

  always_comb begin
    lmask = '0;
    if (is_byte) lmask[cur.boff] = 1'b1;
    else begin
      lmask[{cur.boff[1], 1'b0}] = 1'b1;
      lmask[{cur.boff[1], 1'b1}] = 1'b1;
    end
  end

  genvar j;
  generate
    for (j = 0; j < NUM_LANES; j++) begin : g_lane
      assign wlane[j] = is_byte ? cur.wlo[7:0] : cur.wlo[8*(j%2) +: 8];
      lsu_lane u_lane (
        .sel   (lmask[j]),
        .rbyte (rlane[j]),
        .wbyte (wlane[j]),
        .mbyte (mlane[j])
      );
    end
  endgenerate

  logic [7:0]   lbyte;
  logic [15:0]  lhalf;
  logic [n-1:0] ld_val;

  assign lbyte = rlane[cur.boff];
  assign lhalf = {rlane[{cur.boff[1], 1'b1}], rlane[{cur.boff[1], 1'b0}]};

  always_comb begin
    ld_val = ramDataR;
    case (cur.f3)
      3'b000:  ld_val = {{(n-8){lbyte[7]}}, lbyte};
      3'b100:  ld_val = {{(n-8){1'b0}}, lbyte};
      3'b001:  ld_val = {{(n-16){lhalf[15]}}, lhalf};
      3'b101:  ld_val = {{(n-16){1'b0}}, lhalf};
      default: ld_val = ramDataR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cur      <= '0;
      rdata    <= '0;
      ramAddr  <= '0;
      ramDataW <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      ramR     <= 1'b0;
      ramW     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      ramR <= 1'b0;
      ramW <= 1'b0;
      case (state)
        IDLE: if (req) begin
          if (bad) err <= 1'b1;
          else begin
            cur     <= '{wr: memWrite, f3: funct3, boff: addr[1:0], wlo: wdata[15:0]};
            ramAddr <= {2'b00, addr[AW-1:2]};
            // Full-word stores skip the read; everything else reads first.
            if (memWrite && funct3 == 3'b010) begin
              ramW     <= 1'b1;
              ramDataW <= wdata;
              state    <= WR;
            end else begin
              ramR  <= 1'b1;
              state <= RD;
            end
          end
        end
        RD:  state <= cur.wr ? MRG : CAP;
        CAP: begin
          rdata <= ld_val;
          done  <= 1'b1;
          state <= IDLE;
        end
        MRG: begin
          ramDataW <= mlane;
          ramW     <= 1'b1;
          state    <= WR;
        end
        WR: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a behavioural 1-cycle registered ram.

module tb_lsu_ctrl;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, memWrite = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata, ramAddr, ramDataW;
  logic [31:0] ramDataR = '0;
  logic        done, err, busy, ramR, ramW;

  always #5 clock = ~clock;

  lsu_ctrl #(.n(32), .AW(32)) dut (
    .clock(clock), .reset(reset), .req(req), .memWrite(memWrite),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .done(done), .err(err), .busy(busy), .ramR(ramR), .ramW(ramW),
    .ramAddr(ramAddr), .ramDataW(ramDataW), .ramDataR(ramDataR)
  );

  logic [31:0] mem [0:63];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  always @(posedge clock) begin
    if (ramR) ramDataR <= mem[ramAddr[5:0]];
    if (ramW) mem[ramAddr[5:0]] <= ramDataW;
    if (pl_en) mem[pl_addr] <= pl_data;
  end

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    @(negedge clock);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clock);
    pl_en = 1'b0;
  endtask

  // Caller is at a negedge: this drives a request for cycle 0.
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req = 1'b1; memWrite = w; funct3 = f3; addr = a; wdata = wd;
    @(posedge clock);
    #1 req = 1'b0;
  endtask

  int          dc, ec, rc, wc, bcnt, both;
  logic [31:0] wdat, raddr, waddr;

  task automatic observe();
    dc = -1; ec = -1; rc = -1; wc = -1; bcnt = 0; both = 0;
    wdat = 'x; raddr = 'x; waddr = 'x;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clock);
      if (done && dc < 0) dc = cyc;
      if (err && ec < 0) ec = cyc;
      if (ramR && rc < 0) begin rc = cyc; raddr = ramAddr; end
      if (ramW && wc < 0) begin wc = cyc; wdat = ramDataW; waddr = ramAddr; end
      if (busy) bcnt++;
      if (ramR && ramW) both++;
    end
  endtask

  task automatic run(input string tag, input logic w, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int edone, input int erd, input int ewr, input int eerr);
    @(negedge clock);
    issue(w, f3, a, wd);
    observe();
    check({tag, ".done_cyc"}, dc, edone);
    check({tag, ".rd_cyc"}, rc, erd);
    check({tag, ".wr_cyc"}, wc, ewr);
    check({tag, ".err_cyc"}, ec, eerr);
    check({tag, ".busy_cycles"}, bcnt, (edone > 0) ? edone - 1 : 0);
    check({tag, ".r_and_w"}, both, 0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst.rdata", rdata, 32'h0);
    check("rst.ramAddr", ramAddr, 32'h0);
    check("rst.ramDataW", ramDataW, 32'h0);
    check("rst.flags", {27'b0, done, err, busy, ramR, ramW}, 32'h0);
    reset = 1'b0;

    preload(6'd6, 32'h000F4240);
    run("lw", 1'b0, 3'b010, 32'h18, 32'h0, 3, 1, -1, -1);
    check("lw.addr", raddr, 32'd6);
    check("lw.rdata", rdata, 32'h000F4240);

    preload(6'd6, 32'h80FF1234);
    run("lb", 1'b0, 3'b000, 32'h1B, 32'h0, 3, 1, -1, -1);
    check("lb.rdata", rdata, 32'hFFFFFF80);
    run("lbu", 1'b0, 3'b100, 32'h1B, 32'h0, 3, 1, -1, -1);
    check("lbu.rdata", rdata, 32'h00000080);
    run("lhu", 1'b0, 3'b101, 32'h1A, 32'h0, 3, 1, -1, -1);
    check("lhu.rdata", rdata, 32'h000080FF);
    run("lh", 1'b0, 3'b001, 32'h1A, 32'h0, 3, 1, -1, -1);
    check("lh.rdata", rdata, 32'hFFFF80FF);
    run("lb0", 1'b0, 3'b000, 32'h18, 32'h0, 3, 1, -1, -1);
    check("lb0.rdata", rdata, 32'h00000034);
    run("lh0", 1'b0, 3'b001, 32'h18, 32'h0, 3, 1, -1, -1);
    check("lh0.rdata", rdata, 32'h00001234);

    preload(6'd6, 32'h11223344);
    run("sb", 1'b1, 3'b000, 32'h19, 32'hFFFFFFAB, 4, 1, 3, -1);
    check("sb.wdata", wdat, 32'h1122AB44);
    check("sb.waddr", waddr, 32'd6);
    check("sb.mem", mem[6], 32'h1122AB44);

    run("sw", 1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 2, -1, 1, -1);
    check("sw.waddr", waddr, 32'd2);
    check("sw.wdata", wdat, 32'hDEADBEEF);
    check("sw.mem", mem[2], 32'hDEADBEEF);

    preload(6'd7, 32'h12345678);
    run("sh", 1'b1, 3'b001, 32'h1E, 32'h0000CAFE, 4, 1, 3, -1);
    check("sh.wdata", wdat, 32'hCAFE5678);

    // Errors: no access, rdata keeps last load value (0x00001234).
    run("e_lw", 1'b0, 3'b010, 32'h1A, 32'h0, -1, -1, -1, 1);
    check("e_lw.rdata", rdata, 32'h00001234);
    run("e_sh", 1'b1, 3'b001, 32'h05, 32'h0, -1, -1, -1, 1);
    run("e_f3", 1'b0, 3'b011, 32'h00, 32'h0, -1, -1, -1, 1);
    run("e_sbu", 1'b1, 3'b100, 32'h00, 32'h0, -1, -1, -1, 1);
    check("e_sbu.mem0", mem[0], 32'h0);
    check("e.rdata", rdata, 32'h00001234);

    // Reset in the MRG cycle of an SH.
    preload(6'd7, 32'h12345678);
    @(negedge clock);
    issue(1'b1, 3'b001, 32'h1C, 32'h0000BEEF);
    @(negedge clock);
    check("rstmid.ramR_c1", ramR, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rstmid.busy", busy, 1'b0);
    check("rstmid.ramW", ramW, 1'b0);
    check("rstmid.done", done, 1'b0);
    reset = 1'b0;
    observe();
    check("rstmid.later_w", wc, -1);
    check("rstmid.mem", mem[7], 32'h12345678);

    // Back-to-back: second LW issued in the first LW's done cycle.
    preload(6'd3, 32'h01020304);
    preload(6'd4, 32'h0A0B0C0D);
    @(negedge clock);
    issue(1'b0, 3'b010, 32'h0C, 32'h0);
    dc = -1;
    for (int cyc = 1; cyc <= 6 && dc < 0; cyc++) begin
      @(negedge clock);
      if (done) dc = cyc;
    end
    check("b2b.first_done", dc, 3);
    check("b2b.first_rdata", rdata, 32'h01020304);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    observe();
    check("b2b.second_done", dc, 3);
    check("b2b.second_rdata", rdata, 32'h0A0B0C0D);
    check("b2b.second_raddr", raddr, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store initiator between the CPU datapath and the word-organised synchronous ram (1-cycle registered read, word write).
- Takes one RV32I load/store per request: LB/LH/LW/LBU/LHU/SB/SH/SW.
- Converts byte addresses to word addresses and extracts/extends sub-word loads.
- Performs sub-word stores as read-modify-write; stalls the CPU via busy until done.

Parameters:
- n, 32, data width; only 32 is supported (funct3 lane logic assumes 4 bytes).
- AW, 32, byte-address width from the datapath (rs1+imm).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req  in  1  request strobe; sampled only in IDLE
- memWrite  in  1  1 = store, 0 = load
- funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  AW  byte address
- wdata  in  n  store data (rs2)
- rdata  out  n  load result, sign/zero extended; holds until next load completes
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse: misaligned or illegal funct3
- busy  out  1  high whenever state != IDLE
- ramR  out  1  ram read enable
- ramW  out  1  ram write enable
- ramAddr  out  AW  word address = {2'b00, addr[AW-1:2]}
- ramDataW  out  n  ram write data
- ramDataR  in  n  ram registered read data

Behaviour:
- Reset clears: state IDLE; rdata, ramAddr, ramDataW = 0; done, err, ramR, ramW = 0.
- Registered outputs: ramR, ramW, ramAddr, ramDataW, rdata, done, err. busy is combinational from state.
- On acceptance (IDLE with req=1), latch addr, funct3, wdata and memWrite.
- Inputs are ignored outside IDLE. A req in the done cycle is accepted, because state is already IDLE.
- States: IDLE, RD, CAP, MRG, WR.
- Load: IDLE→RD (ramR=1) → CAP → IDLE.
  - In CAP, ramDataR is valid; rdata <= extracted value and done <= 1.
  - req in cycle 0 gives done in cycle 3.
- SW: IDLE→WR (ramW=1, ramDataW=wdata) → IDLE. done in cycle 2.
- SB/SH: IDLE→RD → MRG → WR → IDLE.
  - In MRG, ramDataW <= ramDataR with the target lane replaced by wdata[7:0] (SB) or wdata[15:0] (SH).
  - done in cycle 4.
- Lanes are little-endian:
  - byte k = bits [8k+7:8k], with k = addr[1:0];
  - halfword = bits [16*addr[1]+15 : 16*addr[1]].
- Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes through unchanged.
- ramR is high only in the RD cycle and ramW only in the WR cycle; they are never both high.
- ramAddr holds its value through the whole access.
- Error conditions, checked at acceptance:
  - H/HU with addr[0]=1;
  - W with addr[1:0]!=0;
  - funct3 in {011, 110, 111};
  - store with funct3 100/101.
- On error:
  - err=1 in cycle 1;
  - no ram access; state stays IDLE;
  - done not asserted; rdata unchanged.
- Reset mid-operation: returns to IDLE at the reset edge and no later ram access occurs. A ramW already high in the reset cycle is still sampled by the ram at that edge; this is accepted.

Test Plan:
- Reset → all outputs 0 and busy=0. Then LW addr 0x18 with ram[6]=0x000F4240 → ramR in cycle 1 with ramAddr=6; done in cycle 3 with rdata=0x000F4240.
- LB addr 0x1B with ram[6]=0x80FF1234 → rdata=0xFFFFFF80. LBU same address → 0x00000080. LHU addr 0x1A → 0x000080FF.
- SB wdata=0xAB at addr 0x19 with ram[6]=0x11223344 → ramR cycle 1; ramW cycle 3 with ramDataW=0x1122AB44; done cycle 4.
- SW wdata=0xDEADBEEF at addr 0x08 → ramW cycle 1, ramAddr=2; done cycle 2; ramR never high.
- LW addr 0x1A or SH addr 0x05 → err pulse in cycle 1; ramR/ramW stay 0; busy stays 0; rdata unchanged.
- SH issued, reset asserted in the MRG cycle → next cycle state IDLE, ramW never asserted, done=0. Back-to-back: LW accepted in the previous access's done cycle → completes 3 cycles later.
